// File: rtl/fb_pkg.sv
// Shared types for the framebuffer fill engine.
//   fb_mode_e   : drawing command selector carried on cmd_mode_i
//   fb_status_e : completion status reported on status_o
//   fb_state_e  : engine FSM state
package fb_pkg;

  typedef enum logic [1:0] {
    FB_CLEAR = 2'd0,
    FB_HLINE = 2'd1,
    FB_VLINE = 2'd2,
    FB_RECT  = 2'd3
  } fb_mode_e;

  typedef enum logic [1:0] {
    FB_OK       = 2'd0,
    FB_CLIPPED  = 2'd1,
    FB_REJECTED = 2'd2,
    FB_ABORTED  = 2'd3
  } fb_status_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fb_raster_cursor.sv
// Raster-order pixel cursor for the fill engine.
// Ports:
//   clk_i, arstn_i  : clock, synchronous active-low reset
//   load_i          : load rectangle bounds and park cursor at (x0_i, y0_i)
//   x0_i/x1_i       : inclusive x span (x0_i <= x1_i)
//   y0_i/y1_i       : inclusive y span (y0_i <= y1_i)
//   adv_i           : current pixel accepted, step to the next one
//   x_o, y_o        : current cursor position
//   last_o          : cursor sits on the final pixel (x1, y1)
module fb_raster_cursor #(
  parameter int ADDR_X_BITS = 11,
  parameter int ADDR_Y_BITS = 11
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   load_i,
  input  logic [ADDR_X_BITS-1:0] x0_i,
  input  logic [ADDR_X_BITS-1:0] x1_i,
  input  logic [ADDR_Y_BITS-1:0] y0_i,
  input  logic [ADDR_Y_BITS-1:0] y1_i,
  input  logic                   adv_i,
  output logic [ADDR_X_BITS-1:0] x_o,
  output logic [ADDR_Y_BITS-1:0] y_o,
  output logic                   last_o
);

  logic [ADDR_X_BITS-1:0] x_q, x0_q, x1_q;
  logic [ADDR_Y_BITS-1:0] y_q, y1_q;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
    end else if (load_i) begin
      x_q  <= x0_i;
      y_q  <= y0_i;
      x0_q <= x0_i;
      x1_q <= x1_i;
      y1_q <= y1_i;
    end else if (adv_i) begin
      // Full-width equality against the row end; wrap back to x0 on a new row.
      if (x_q == x1_q) begin
        x_q <= x0_q;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/fb_fill_engine.sv
// Framebuffer fill engine: accepts one drawing command (clear, hline, vline,
// rect) and emits one pixel write per accepted cycle in raster order.
// Ports:
//   clk_i, arstn_i          : clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o : command handshake
//   cmd_mode_i, cmd_x0_i, cmd_x1_i, cmd_y0_i, cmd_y1_i, cmd_color_i : command
//   abort_i                 : stop the running command
//   wr_ready_i              : framebuffer accepts the write this cycle
//   addr_x_o, addr_y_o, color_o, we_o : framebuffer write port
//   busy_o, done_o, status_o, px_cnt_o : progress and completion reporting
module fb_fill_engine #(
  parameter int ADDR_X_BITS = 11,
  parameter int ADDR_Y_BITS = 11,
  parameter int HD          = 1280,
  parameter int VD          = 1024,
  parameter int COLOR_BITS  = 2
) (
  input  logic                               clk_i,
  input  logic                               arstn_i,
  input  logic                               cmd_valid_i,
  output logic                               cmd_ready_o,
  input  logic [1:0]                         cmd_mode_i,
  input  logic [ADDR_X_BITS-1:0]             cmd_x0_i,
  input  logic [ADDR_X_BITS-1:0]             cmd_x1_i,
  input  logic [ADDR_Y_BITS-1:0]             cmd_y0_i,
  input  logic [ADDR_Y_BITS-1:0]             cmd_y1_i,
  input  logic [COLOR_BITS-1:0]              cmd_color_i,
  input  logic                               abort_i,
  input  logic                               wr_ready_i,
  output logic [ADDR_X_BITS-1:0]             addr_x_o,
  output logic [ADDR_Y_BITS-1:0]             addr_y_o,
  output logic [COLOR_BITS-1:0]              color_o,
  output logic                               we_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [1:0]                         status_o,
  output logic [ADDR_X_BITS+ADDR_Y_BITS-1:0] px_cnt_o
);
  import fb_pkg::*;

  localparam int PXW = ADDR_X_BITS + ADDR_Y_BITS;
  localparam logic [ADDR_X_BITS-1:0] X_MAX = ADDR_X_BITS'(HD - 1);
  localparam logic [ADDR_Y_BITS-1:0] Y_MAX = ADDR_Y_BITS'(VD - 1);

  if ((HD < 1) || (longint'(HD) > (longint'(1) << ADDR_X_BITS))) begin : g_hd_chk
    $error("HD-1 does not fit in ADDR_X_BITS");
  end
  if ((VD < 1) || (longint'(VD) > (longint'(1) << ADDR_Y_BITS))) begin : g_vd_chk
    $error("VD-1 does not fit in ADDR_Y_BITS");
  end
  if ((longint'(HD) * longint'(VD)) >= (longint'(1) << PXW)) begin : g_cnt_chk
    $error("HD*VD does not fit in px_cnt_o");
  end

  function automatic logic [ADDR_X_BITS-1:0] sat_x(input logic [ADDR_X_BITS-1:0] v);
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [ADDR_Y_BITS-1:0] sat_y(input logic [ADDR_Y_BITS-1:0] v);
    return (v > Y_MAX) ? Y_MAX : v;
  endfunction

  fb_state_e              state_q, state_d;
  fb_mode_e               mode_q;
  fb_status_e             pend_q, status_q;
  logic [ADDR_X_BITS-1:0] x0_q, x1_q;
  logic [ADDR_Y_BITS-1:0] y0_q, y1_q;
  logic [COLOR_BITS-1:0]  color_q;
  logic [PXW-1:0]         px_cnt_q;

  logic [ADDR_X_BITS-1:0] fx0, fx1, nx0, nx1, cur_x;
  logic [ADDR_Y_BITS-1:0] fy0, fy1, ny0, ny1, cur_y;
  logic                   reject, clip, accept, last;

  // Mode forcing, corner normalisation and clip/reject decision for PREP.
  always_comb begin
    fx0 = x0_q;
    fx1 = x1_q;
    fy0 = y0_q;
    fy1 = y1_q;
    case (mode_q)
      FB_CLEAR: begin
        fx0 = '0;
        fx1 = X_MAX;
        fy0 = '0;
        fy1 = Y_MAX;
      end
      FB_HLINE: fy1 = y0_q;
      FB_VLINE: fx1 = x0_q;
      default:  ;
    endcase
    nx0    = (fx0 <= fx1) ? fx0 : fx1;
    nx1    = (fx0 <= fx1) ? fx1 : fx0;
    ny0    = (fy0 <= fy1) ? fy0 : fy1;
    ny1    = (fy0 <= fy1) ? fy1 : fy0;
    reject = (nx0 > X_MAX) || (ny0 > Y_MAX);
    clip   = (nx1 > X_MAX) || (ny1 > Y_MAX);
  end

  assign accept = (state_q == ST_DRAW) && wr_ready_i;

  fb_raster_cursor #(
    .ADDR_X_BITS(ADDR_X_BITS),
    .ADDR_Y_BITS(ADDR_Y_BITS)
  ) u_cursor (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .load_i (state_q == ST_PREP),
    .x0_i   (nx0),
    .x1_i   (sat_x(nx1)),
    .y0_i   (ny0),
    .y1_i   (sat_y(ny1)),
    .adv_i  (accept),
    .x_o    (cur_x),
    .y_o    (cur_y),
    .last_o (last)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!arstn_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; abort outranks reject and last-pixel completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid_i) state_d = ST_PREP;
      ST_PREP: state_d = (abort_i || reject) ? ST_DONE : ST_DRAW;
      ST_DRAW: if (abort_i || (accept && last)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready_o = (state_q == ST_IDLE);
    we_o        = (state_q == ST_DRAW);
    busy_o      = (state_q == ST_PREP) || (state_q == ST_DRAW);
    done_o      = (state_q == ST_DONE);
  end

  // Command capture, pixel count and status tracking
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      mode_q   <= FB_CLEAR;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      px_cnt_q <= '0;
      pend_q   <= FB_OK;
      status_q <= FB_OK;
    end else begin
      if ((state_q == ST_IDLE) && cmd_valid_i) begin
        mode_q  <= fb_mode_e'(cmd_mode_i);
        x0_q    <= cmd_x0_i;
        x1_q    <= cmd_x1_i;
        y0_q    <= cmd_y0_i;
        y1_q    <= cmd_y1_i;
        color_q <= cmd_color_i;
      end
      if (state_q == ST_PREP) begin
        px_cnt_q <= '0;
        pend_q   <= clip ? FB_CLIPPED : FB_OK;
        if (mode_q == FB_CLEAR) color_q <= '0;
        if (abort_i)     status_q <= FB_ABORTED;
        else if (reject) status_q <= FB_REJECTED;
      end
      if (accept) px_cnt_q <= px_cnt_q + PXW'(1);
      if (state_q == ST_DRAW) begin
        if (abort_i)             status_q <= FB_ABORTED;
        else if (accept && last) status_q <= pend_q;
      end
    end
  end

  assign addr_x_o = cur_x;
  assign addr_y_o = cur_y;
  assign color_o  = color_q;
  assign status_o = status_q;
  assign px_cnt_o = px_cnt_q;

endmodule

// File: tb/tb_fb_fill_engine.sv
// Scoreboard bench for fb_fill_engine: stimulus pushes expected pixel writes
// and completions into queues; a negedge monitor pops and compares them.
module tb_fb_fill_engine;

  localparam int XB = 11;
  localparam int YB = 11;
  localparam int CB = 2;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_mode = '0;
  logic [XB-1:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [YB-1:0] cmd_y0 = '0, cmd_y1 = '0;
  logic [CB-1:0] cmd_color = '0;
  logic          abort = 1'b0;
  logic          wr_ready = 1'b1;
  logic [XB-1:0] addr_x;
  logic [YB-1:0] addr_y;
  logic [CB-1:0] color;
  logic          we, busy, done;
  logic [1:0]    status;
  logic [XB+YB-1:0] px_cnt;

  fb_fill_engine dut (
    .clk_i(clk), .arstn_i(arstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_mode_i(cmd_mode),
    .cmd_x0_i(cmd_x0), .cmd_x1_i(cmd_x1),
    .cmd_y0_i(cmd_y0), .cmd_y1_i(cmd_y1),
    .cmd_color_i(cmd_color), .abort_i(abort), .wr_ready_i(wr_ready),
    .addr_x_o(addr_x), .addr_y_o(addr_y), .color_o(color), .we_o(we),
    .busy_o(busy), .done_o(done), .status_o(status), .px_cnt_o(px_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int c; } px_t;
  typedef struct { int st; int cnt; } dn_t;
  px_t exp_px[$];
  dn_t exp_dn[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push_px(input int x, input int y, input int c);
    px_t p;
    p.x = x; p.y = y; p.c = c;
    exp_px.push_back(p);
  endtask

  task automatic push_dn(input int st, input int cnt);
    dn_t d;
    d.st = st; d.cnt = cnt;
    exp_dn.push_back(d);
  endtask

  // Monitor: compares every accepted write and every done pulse
  always @(negedge clk) begin : mon
    px_t e;
    dn_t d;
    if (we === 1'b1 && wr_ready === 1'b1) begin
      if (exp_px.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL px_extra: got write (%0d,%0d) required none", addr_x, addr_y);
      end else begin
        e = exp_px.pop_front();
        chk("px_x", 32'(addr_x), e.x);
        chk("px_y", 32'(addr_y), e.y);
        chk("px_color", 32'(color), e.c);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_dn.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done_extra: got done status %0d required none", status);
      end else begin
        d = exp_dn.pop_front();
        chk("done_status", 32'(status), d.st);
        chk("done_px_cnt", 32'(px_cnt), d.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [1:0] m, input int x0, input int x1,
                          input int y0, input int y1, input int c);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_ready_timeout: got 0 required 1");
    end
    cmd_mode = m;
    cmd_x0 = XB'(x0); cmd_x1 = XB'(x1);
    cmd_y0 = YB'(y0); cmd_y1 = YB'(y1);
    cmd_color = CB'(c);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
      n++;
    end
    if (n >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got busy required idle");
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [XB-1:0] hx;
    logic [YB-1:0] hy;
    bit have;
    int dc;

    // Reset state
    arstn = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_we", 32'(we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_px_cnt", 32'(px_cnt), 0);
    chk("rst_addr_x", 32'(addr_x), 0);
    chk("rst_addr_y", 32'(addr_y), 0);
    chk("rst_color", 32'(color), 0);
    @(posedge clk); #1;
    arstn = 1'b1;
    tick();

    // HLINE 10..13 at y=5, exact latency profile
    for (int x = 10; x <= 13; x++) push_px(x, 5, 2);
    push_dn(0, 4);
    send_cmd(2'd1, 10, 13, 5, 5, 2);
    @(negedge clk);
    chk("hl_prep_we", 32'(we), 0);
    chk("hl_prep_busy", 32'(busy), 1);
    chk("hl_prep_ready", 32'(cmd_ready), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hl_draw_we", 32'(we), 1);
    end
    @(negedge clk);
    chk("hl_done", 32'(done), 1);
    chk("hl_done_busy", 32'(busy), 0);
    chk("hl_done_we", 32'(we), 0);
    @(negedge clk);
    chk("hl_ready_after", 32'(cmd_ready), 1);
    chk("hl_done_pulse", 32'(done), 0);

    // RECT with swapped corners
    push_px(2, 0, 1); push_px(3, 0, 1); push_px(2, 1, 1); push_px(3, 1, 1);
    push_dn(0, 4);
    send_cmd(2'd3, 3, 2, 1, 0, 1);
    wait_idle();

    // RECT clipped at the right/bottom edges
    push_px(1278, 1022, 3); push_px(1279, 1022, 3);
    push_px(1278, 1023, 3); push_px(1279, 1023, 3);
    push_dn(1, 4);
    send_cmd(2'd3, 1278, 1500, 1022, 1023, 3);
    wait_idle();

    // RECT starting off-screen is rejected
    push_dn(2, 0);
    send_cmd(2'd3, 1280, 1285, 0, 0, 1);
    @(negedge clk);
    chk("rej_prep_done", 32'(done), 0);
    @(negedge clk);
    chk("rej_done", 32'(done), 1);
    chk("rej_we", 32'(we), 0);
    @(negedge clk);
    chk("rej_status_held", 32'(status), 2);

    // VLINE x=7, y 0..3 with wr_ready low every other cycle
    for (int y = 0; y <= 3; y++) push_px(7, y, 2);
    push_dn(0, 4);
    wr_ready = 1'b1;
    send_cmd(2'd2, 7, 99, 0, 3, 2);
    have = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (we && !wr_ready) begin
        hx = addr_x; hy = addr_y; have = 1'b1;
      end else if (we && wr_ready && have) begin
        chk("stall_hold_x", 32'(addr_x), 32'(hx));
        chk("stall_hold_y", 32'(addr_y), 32'(hy));
        have = 1'b0;
      end
      @(posedge clk); #1;
      wr_ready = ~wr_ready;
      if (cmd_ready) break;
    end
    wr_ready = 1'b1;
    wait_idle();

    // CLEAR aborted on the cycle of its 100th write
    for (int x = 0; x < 100; x++) push_px(x, 0, 0);
    push_dn(3, 100);
    send_cmd(2'd0, 5, 6, 7, 8, 3);
    for (int i = 0; i < 100; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_we_low", 32'(we), 0);
    chk("abort_done", 32'(done), 1);
    wait_idle();

    // Reset in the middle of a RECT drops it silently
    push_px(0, 0, 1); push_px(1, 0, 1); push_px(2, 0, 1);
    send_cmd(2'd3, 0, 9, 0, 9, 1);
    tick(); tick(); tick();
    dc = done_cnt;
    arstn = 1'b0;
    tick();
    arstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_px_cnt", 32'(px_cnt), 0);
    tick(); tick();
    chk("mid_rst_no_done", 32'(done_cnt), 32'(dc));

    // Fresh HLINE after the reset
    push_px(20, 7, 3); push_px(21, 7, 3); push_px(22, 7, 3);
    push_dn(0, 3);
    send_cmd(2'd1, 22, 20, 7, 500, 3);
    wait_idle();
    tick();

    chk("px_queue_empty", 32'(exp_px.size()), 0);
    chk("dn_queue_empty", 32'(exp_dn.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
